mac_operand_feeder: RTL and testbench
=====================================

// Module: mac_operand_feeder
// PURPOSE
//   Sequencer on the input side of the fixed-point MAC. On a start request it reads two operand vectors
//   from synchronous-read memories A and B. It streams the element pairs into the MAC as in_1/in_2/in_valid,
//   with mac_reset on the first beat. It then captures the MAC's final accumulated output and presents it
//   as one dot-product result on a valid/ready port. Sits between the layer controller and one MAC lane.
// PARAMETERS
//   T_WIDTH    32  operand/result width; matches the MAC T_WIDTH
//   ADDR_WIDTH 10  operand memory address width
//   LEN_WIDTH  11  vector length field width (max length 2**ADDR_WIDTH)
// PORTS
//   clk          in   1           clock, all logic on rising edge
//   rst          in   1           asynchronous, active-low reset (asserted at 0)
//   start        in   1           request pulse; sampled only in IDLE
//   len          in   LEN_WIDTH   element count for this request
//   a_base       in   ADDR_WIDTH  first address in memory A
//   b_base       in   ADDR_WIDTH  first address in memory B
//   mode_in      in   3           MAC output-format select; latched on start
//   busy         out  1           high in any state other than IDLE
//   a_rd_en      out  1           memory A read strobe
//   a_addr       out  ADDR_WIDTH  memory A address
//   a_rdata      in   T_WIDTH     memory A data; valid 1 cycle after a_rd_en
//   b_rd_en      out  1           memory B read strobe (always equal to a_rd_en)
//   b_addr       out  ADDR_WIDTH  memory B address
//   b_rdata      in   T_WIDTH     memory B data; valid 1 cycle after b_rd_en
//   mac_in_1     out  T_WIDTH     to MAC in_1 (= a_rdata)
//   mac_in_2     out  T_WIDTH     to MAC in_2 (= b_rdata)
//   mac_in_valid out  1           to MAC in_valid
//   mac_reset    out  1           to MAC mac_reset; high on the first beat only
//   mac_mode     out  3           to MAC mode (latched mode_in)
//   mac_out      in   T_WIDTH     from MAC out
//   mac_out_valid in  1           from MAC out_valid
//   result       out  T_WIDTH     captured dot product
//   result_valid out  1           result available
//   result_ready in   1           consumer accepts result
// BEHAVIOUR
//   Reset: state=IDLE; busy, a/b_rd_en, mac_in_valid, mac_reset, result_valid = 0.
//     Addresses, result and mac_mode = 0. A reset mid-operation abandons the request and leaves the MAC
//     undisturbed. The next request's mac_reset clears the MAC.
//   FSM IDLE -> ISSUE -> DRAIN -> HOLD -> IDLE.
//   IDLE: on start with len!=0, latch len, bases and mode, then go to ISSUE.
//     On start with len==0, load result=0 and go to HOLD without touching the memories or the MAC.
//   ISSUE: one read per cycle for len cycles at addresses base+i, i=0..len-1. No gaps.
//     Rd_en is delayed 1 cycle to form mac_in_valid. The first-beat and last-beat flags are delayed the same way.
//     mac_reset = delayed first-beat flag, gated by mac_in_valid. When len==1, mac_reset and the last beat
//     coincide. After beat len-1 is issued, go to DRAIN.
//   DRAIN: wait for mac_out_valid coincident with the twice-delayed last flag. Register mac_out into result,
//     then go to HOLD.
//   HOLD: result_valid=1 and result stable until result_valid&&result_ready, then go to IDLE (busy drops on the
//     same edge).
//   Latency: sampling edge of start = cycle 0. Reads occur in cycles 1..len. MAC beats occur in cycles 2..len+1.
//     mac_out_valid with the final sum arrives in cycle len+2. result_valid rises in cycle len+3.
//   Boundaries:
//     - start while busy is ignored.
//     - Address arithmetic wraps modulo 2**ADDR_WIDTH.
//     - len > 2**ADDR_WIDTH is truncated to its low LEN_WIDTH bits with no error.
//     - result_ready held high gives back-to-back requests. A new start is accepted in the cycle after the handshake.
// CONFIGURATION
//   MAC_FEED_STRIDE_EN defined:
//     - Adds inputs a_stride and b_stride (ADDR_WIDTH each), latched on start.
//     - Addresses become base + i*stride, built by accumulation and wrapping modulo 2**ADDR_WIDTH.
//     - Stride 0 rereads one element len times.
//   Undefined: no stride ports; stride is fixed at 1.
// STRUCTURE
//   Shared package: FSM state enum (IDLE/ISSUE/DRAIN/HOLD, 2-bit encoding) and MAC mode constants (3'b000..3'b011).
//   Sub-module mac_feed_addr_gen: base/stride latch, address accumulator and beat counter. It emits first, last and done.
//   Top level: FSM, 1-cycle and 2-cycle flag delay pipes, result register.
// TESTING
//   1. len=4, A=[1,2,3,4], B=[5,6,7,8], mode 000:
//      mac_reset only on beat 0, 4 consecutive in_valid beats, result=70, result_valid rises at cycle 7.
//   2. len=1, A=[-3], B=[9]: mac_reset and last beat coincide; result=-27 (0xFFFFFFE5).
//   3. len=0: no rd_en, no mac_in_valid; result=0 with result_valid at cycle 1.
//   4. result_ready held low 10 cycles in HOLD: result stable, a second start ignored, busy=1.
//      Ready then high: idle next cycle.
//   5. rst asserted in the middle of ISSUE of a len=8 run: all outputs 0 immediately.
//      A new len=2 run after release gives the correct sum (MAC cleared by mac_reset).
//   6. a_base=1022, len=4: addresses 1022,1023,0,1.
//      With MAC_FEED_STRIDE_EN, stride=3, base=0: addresses 0,3,6,9.

Source files
------------

// File: rtl/mac_operand_feeder_pkg.sv
// Shared definitions for the MAC operand feeder: sequencer state encoding
// and the MAC output-format select codes carried on mac_mode.
package mac_operand_feeder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_DRAIN = 2'b10,
      ST_HOLD  = 2'b11
   } feed_state_t;

   localparam logic [2:0] MAC_MODE_0 = 3'b000;
   localparam logic [2:0] MAC_MODE_1 = 3'b001;
   localparam logic [2:0] MAC_MODE_2 = 3'b010;
   localparam logic [2:0] MAC_MODE_3 = 3'b011;

endpackage

// File: rtl/mac_feed_addr_gen.sv
// Address generator for the MAC operand feeder. Latches the bases and
// strides on load, then issues one read per cycle for len cycles with no
// gaps, flagging the first and last beat. Addresses wrap modulo
// 2**ADDR_WIDTH because the accumulators are exactly ADDR_WIDTH wide.
module mac_feed_addr_gen
   import mac_operand_feeder_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic [ADDR_WIDTH-1:0] a_base,
   input  logic [ADDR_WIDTH-1:0] b_base,
   input  logic [ADDR_WIDTH-1:0] a_stride,
   input  logic [ADDR_WIDTH-1:0] b_stride,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] a_addr,
   output logic [ADDR_WIDTH-1:0] b_addr,
   output logic                  first,
   output logic                  last,
   output logic                  done
);

   logic [ADDR_WIDTH-1:0] a_stride_q;
   logic [ADDR_WIDTH-1:0] b_stride_q;
   // beats still to issue after the one currently on the read port
   logic [LEN_WIDTH-1:0]  remain;

   // the final beat is on the read port this cycle
   assign done = rd_en & last;

   // latch request, then step addresses and beat counter once per issued read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_en      <= 1'b0;
         a_addr     <= {ADDR_WIDTH{1'b0}};
         b_addr     <= {ADDR_WIDTH{1'b0}};
         a_stride_q <= {ADDR_WIDTH{1'b0}};
         b_stride_q <= {ADDR_WIDTH{1'b0}};
         remain     <= {LEN_WIDTH{1'b0}};
         first      <= 1'b0;
         last       <= 1'b0;
      end else if (load) begin
         rd_en      <= 1'b1;
         a_addr     <= a_base;
         b_addr     <= b_base;
         a_stride_q <= a_stride;
         b_stride_q <= b_stride;
         remain     <= len - LEN_WIDTH'(1);
         first      <= 1'b1;
         last       <= (len == LEN_WIDTH'(1));
      end else if (rd_en) begin
         if (remain == {LEN_WIDTH{1'b0}}) begin
            rd_en <= 1'b0;
            first <= 1'b0;
            last  <= 1'b0;
         end else begin
            a_addr <= a_addr + a_stride_q;
            b_addr <= b_addr + b_stride_q;
            remain <= remain - LEN_WIDTH'(1);
            first  <= 1'b0;
            last   <= (remain == LEN_WIDTH'(1));
         end
      end else begin
         rd_en <= 1'b0;
      end
   end

endmodule

// File: rtl/mac_operand_feeder.sv
// MAC operand feeder: on start, streams len element pairs from memories A
// and B into one MAC lane (mac_reset on the first beat), then captures the
// final accumulation and offers it on a valid/ready result port.
// Optional feature macro MAC_FEED_STRIDE_EN adds per-memory stride inputs;
// without it the stride is fixed at 1.
module mac_operand_feeder
   import mac_operand_feeder_pkg::*;
#(
   parameter int T_WIDTH    = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic [ADDR_WIDTH-1:0] a_base,
   input  logic [ADDR_WIDTH-1:0] b_base,
`ifdef MAC_FEED_STRIDE_EN
   input  logic [ADDR_WIDTH-1:0] a_stride,
   input  logic [ADDR_WIDTH-1:0] b_stride,
`endif
   input  logic [2:0]            mode_in,
   output logic                  busy,
   output logic                  a_rd_en,
   output logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [T_WIDTH-1:0]    a_rdata,
   output logic                  b_rd_en,
   output logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [T_WIDTH-1:0]    b_rdata,
   output logic [T_WIDTH-1:0]    mac_in_1,
   output logic [T_WIDTH-1:0]    mac_in_2,
   output logic                  mac_in_valid,
   output logic                  mac_reset,
   output logic [2:0]            mac_mode,
   input  logic [T_WIDTH-1:0]    mac_out,
   input  logic                  mac_out_valid,
   output logic [T_WIDTH-1:0]    result,
   output logic                  result_valid,
   input  logic                  result_ready
);

   feed_state_t           state;
   logic                  load;
   logic                  rd_en;
   logic                  first;
   logic                  last;
   logic                  done;
   logic                  last_d1;
   logic                  last_d2;
   logic [ADDR_WIDTH-1:0] a_step;
   logic [ADDR_WIDTH-1:0] b_step;

`ifdef MAC_FEED_STRIDE_EN
   assign a_step = a_stride;
   assign b_step = b_stride;
`else
   assign a_step = ADDR_WIDTH'(1);
   assign b_step = ADDR_WIDTH'(1);
`endif

   // a zero-length request never reaches the address generator
   assign load = (state == ST_IDLE) && start && (len != {LEN_WIDTH{1'b0}});

   assign busy    = (state != ST_IDLE);
   assign a_rd_en = rd_en;
   assign b_rd_en = rd_en;

   // memory read data arrives aligned with mac_in_valid, so it passes straight through
   assign mac_in_1 = a_rdata;
   assign mac_in_2 = b_rdata;

   mac_feed_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .len      (len),
      .a_base   (a_base),
      .b_base   (b_base),
      .a_stride (a_step),
      .b_stride (b_step),
      .rd_en    (rd_en),
      .a_addr   (a_addr),
      .b_addr   (b_addr),
      .first    (first),
      .last     (last),
      .done     (done)
   );

   // sequencer FSM with the flag delay pipes and the result register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         mac_in_valid <= 1'b0;
         mac_reset    <= 1'b0;
         last_d1      <= 1'b0;
         last_d2      <= 1'b0;
         mac_mode     <= 3'b000;
         result       <= {T_WIDTH{1'b0}};
         result_valid <= 1'b0;
      end else begin
         // one cycle of read latency turns the read strobe into a MAC beat
         mac_in_valid <= rd_en;
         mac_reset    <= rd_en & first;
         last_d1      <= rd_en & last;
         // one more cycle for the MAC to present the final sum
         last_d2      <= last_d1;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (len != {LEN_WIDTH{1'b0}}) begin
                     mac_mode <= mode_in;
                     state    <= ST_ISSUE;
                  end else begin
                     result       <= {T_WIDTH{1'b0}};
                     result_valid <= 1'b1;
                     state        <= ST_HOLD;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (done) begin
                  state <= ST_DRAIN;
               end else begin
                  state <= ST_ISSUE;
               end
            end
            ST_DRAIN: begin
               if (mac_out_valid && last_d2) begin
                  result       <= mac_out;
                  result_valid <= 1'b1;
                  state        <= ST_HOLD;
               end else begin
                  state <= ST_DRAIN;
               end
            end
            ST_HOLD: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  state        <= ST_IDLE;
               end else begin
                  state <= ST_HOLD;
               end
            end
            default: begin
               result_valid <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder: synchronous-read memory and
// MAC behavioural models, a table of directed vectors, and hand-written
// sequences for hold/backpressure, mid-run reset and back-to-back requests.
module tb_mac_operand_feeder;

   localparam int TW = 32;
   localparam int AW = 10;
   localparam int LW = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic [AW-1:0] a_base = '0;
   logic [AW-1:0] b_base = '0;
   logic [AW-1:0] a_stride = 10'd1;
   logic [AW-1:0] b_stride = 10'd1;
   logic [2:0]    mode_in = 3'b000;
   logic          busy;
   logic          a_rd_en;
   logic [AW-1:0] a_addr;
   logic [TW-1:0] a_rdata;
   logic          b_rd_en;
   logic [AW-1:0] b_addr;
   logic [TW-1:0] b_rdata;
   logic [TW-1:0] mac_in_1;
   logic [TW-1:0] mac_in_2;
   logic          mac_in_valid;
   logic          mac_reset;
   logic [2:0]    mac_mode;
   logic [TW-1:0] mac_out;
   logic          mac_out_valid = 1'b0;
   logic [TW-1:0] result;
   logic          result_valid;
   logic          result_ready = 1'b0;

   logic [TW-1:0] mem_a [1024];
   logic [TW-1:0] mem_b [1024];
   logic [TW-1:0] acc = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            len;
      logic [AW-1:0] abase;
      logic [AW-1:0] bbase;
      logic [AW-1:0] as;
      logic [AW-1:0] bs;
      logic [2:0]    mode;
      logic [3:0][TW-1:0] a;
      logic [3:0][TW-1:0] b;
      logic [TW-1:0] exp_result;
      int            exp_rv;
   } vec_t;

   vec_t tbl [$];

   always #5 clk = ~clk;

   mac_operand_feeder dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .len           (len),
      .a_base        (a_base),
      .b_base        (b_base),
`ifdef MAC_FEED_STRIDE_EN
      .a_stride      (a_stride),
      .b_stride      (b_stride),
`endif
      .mode_in       (mode_in),
      .busy          (busy),
      .a_rd_en       (a_rd_en),
      .a_addr        (a_addr),
      .a_rdata       (a_rdata),
      .b_rd_en       (b_rd_en),
      .b_addr        (b_addr),
      .b_rdata       (b_rdata),
      .mac_in_1      (mac_in_1),
      .mac_in_2      (mac_in_2),
      .mac_in_valid  (mac_in_valid),
      .mac_reset     (mac_reset),
      .mac_mode      (mac_mode),
      .mac_out       (mac_out),
      .mac_out_valid (mac_out_valid),
      .result        (result),
      .result_valid  (result_valid),
      .result_ready  (result_ready)
   );

   // synchronous-read operand memories, one cycle of read latency
   always @(posedge clk) begin
      if (a_rd_en) a_rdata <= mem_a[a_addr];
      if (b_rd_en) b_rdata <= mem_b[b_addr];
   end

   // MAC lane model: one-cycle latency, not reset by the feeder reset
   always @(posedge clk) begin
      mac_out_valid <= mac_in_valid;
      if (mac_in_valid) acc <= (mac_reset ? 32'd0 : acc) + mac_in_1 * mac_in_2;
   end
   assign mac_out = acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                  name, $signed(act), act, $signed(exp), exp);
      end
   endtask

   function automatic vec_t mk(int l, int ab, int bb, int as, int bs, int md,
                               int a0, int a1, int a2, int a3,
                               int b0, int b1, int b2, int b3, int er, int rv);
      vec_t v;
      v.len = l;
      v.abase = AW'(ab);
      v.bbase = AW'(bb);
      v.as = AW'(as);
      v.bs = AW'(bs);
      v.mode = 3'(md);
      v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
      v.exp_result = er;
      v.exp_rv = rv;
      return v;
   endfunction

   // apply one request and watch every cycle until result_valid (bounded)
   task automatic run_vec(input vec_t v, input int idx, input bit handshake);
      int rd = 0;
      int vb = 0;
      int rv_cyc = -1;
      int addr_bad = 0;
      int rst_bad = 0;
      int gap_bad = 0;
      int busy_bad = 0;
      int mode_bad = 0;
      logic [AW-1:0] ea;
      logic [AW-1:0] eb;
      for (int i = 0; i < 4; i++) begin
         if (i < v.len) begin
            ea = v.abase + v.as * AW'(i);
            eb = v.bbase + v.bs * AW'(i);
            mem_a[ea] = v.a[i];
            mem_b[eb] = v.b[i];
         end
      end
      @(negedge clk);
      start = 1'b1;
      len = LW'(v.len);
      a_base = v.abase;
      b_base = v.bbase;
      a_stride = v.as;
      b_stride = v.bs;
      mode_in = v.mode;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 40 && rv_cyc < 0; c++) begin
         @(negedge clk);
         if (a_rd_en) begin
            ea = v.abase + v.as * AW'(rd);
            eb = v.bbase + v.bs * AW'(rd);
            if (a_addr !== ea || b_addr !== eb || b_rd_en !== 1'b1) begin
               addr_bad++;
               $display("  beat %0d: a_addr=%0d (want %0d) b_addr=%0d (want %0d)", rd, a_addr, ea, b_addr, eb);
            end
            if (c != rd + 1) gap_bad++;
            rd++;
         end
         if (mac_in_valid) begin
            if (mac_reset !== (vb == 0)) rst_bad++;
            if (c != vb + 2) gap_bad++;
            if (mac_mode !== v.mode) mode_bad++;
            vb++;
         end else if (mac_reset) begin
            rst_bad++;
         end
         if (!busy) busy_bad++;
         if (result_valid) rv_cyc = c;
      end
      chk($sformatf("v%0d result", idx), result, v.exp_result);
      chk($sformatf("v%0d result_valid_cycle", idx), 32'(rv_cyc), 32'(v.exp_rv));
      chk($sformatf("v%0d read_count", idx), 32'(rd), 32'(v.len));
      chk($sformatf("v%0d beat_count", idx), 32'(vb), 32'(v.len));
      chk($sformatf("v%0d address_errors", idx), 32'(addr_bad), 32'd0);
      chk($sformatf("v%0d mac_reset_errors", idx), 32'(rst_bad), 32'd0);
      chk($sformatf("v%0d timing_gap_errors", idx), 32'(gap_bad), 32'd0);
      chk($sformatf("v%0d busy_low_errors", idx), 32'(busy_bad), 32'd0);
      chk($sformatf("v%0d mode_errors", idx), 32'(mode_bad), 32'd0);
      if (handshake) begin
         result_ready = 1'b1;
         @(posedge clk);
         #1 result_ready = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d idle_after_handshake", idx), 32'({busy, result_valid}), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int seen;
      int cyc;
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_controls", 32'({busy, a_rd_en, b_rd_en, mac_in_valid, mac_reset, result_valid}), 32'd0);
      chk("reset_addresses", 32'({a_addr, b_addr}), 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_mode", 32'(mac_mode), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // directed vector table
      tbl.push_back(mk(4,   16,  32, 1, 1, 0,  1,  2, 3, 4,  5,  6, 7, 8,  70, 7));
      tbl.push_back(mk(1,   40,  41, 1, 1, 1, -3,  0, 0, 0,  9,  0, 0, 0, -27, 4));
      tbl.push_back(mk(0,   50,  50, 1, 1, 2,  0,  0, 0, 0,  0,  0, 0, 0,   0, 1));
      tbl.push_back(mk(4, 1022, 200, 1, 1, 3,  2,  3, 4, 5,  1,  1, 1, 1,  14, 7));
      tbl.push_back(mk(3,  300, 301, 1, 1, 3, -1, -2, 7, 0,  4, -5, 2, 0,  20, 6));
`ifdef MAC_FEED_STRIDE_EN
      tbl.push_back(mk(4,    0, 512, 3, 3, 0,  1,  1, 1, 1,  1,  2, 3, 4,  10, 7));
`endif
      foreach (tbl[i]) run_vec(tbl[i], i, 1'b1);

      // result held under backpressure; start during HOLD is ignored
      run_vec(mk(2, 60, 61, 1, 1, 1, 3, 4, 0, 0, 10, 20, 0, 0, 110, 5), 90, 1'b0);
      bad = 0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin
            start = 1'b1;
            len = 11'd1;
            a_base = 10'd60;
            b_base = 10'd61;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (result !== 32'd110 || result_valid !== 1'b1 || busy !== 1'b1) bad++;
         if (a_rd_en || mac_in_valid) seen++;
      end
      start = 1'b0;
      chk("hold_stable", 32'(bad), 32'd0);
      chk("hold_no_reads", 32'(seen), 32'd0);
      result_ready = 1'b1;
      @(posedge clk);
      #1 result_ready = 1'b0;
      @(negedge clk);
      chk("hold_release_idle", 32'({busy, result_valid}), 32'd0);
      @(negedge clk);
      chk("hold_start_ignored", 32'({busy, a_rd_en}), 32'd0);

      // reset in the middle of ISSUE for a len=8 run
      for (int i = 0; i < 8; i++) begin
         mem_a[400 + i] = 32'd3;
         mem_b[500 + i] = 32'd5;
      end
      @(negedge clk);
      start = 1'b1;
      len = 11'd8;
      a_base = 10'd400;
      b_base = 10'd500;
      a_stride = 10'd1;
      b_stride = 10'd1;
      mode_in = 3'b010;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_reset_issuing", 32'({busy, a_rd_en, mac_in_valid}), 32'b111);
      rst = 1'b0;
      #1;
      chk("mid_reset_controls", 32'({busy, a_rd_en, b_rd_en, mac_in_valid, mac_reset, result_valid}), 32'd0);
      chk("mid_reset_addr_mode", 32'({a_addr, b_addr, mac_mode}), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_vec(mk(2, 410, 510, 1, 1, 0, 2, 3, 0, 0, 4, 5, 0, 0, 23, 5), 91, 1'b1);

      // back-to-back requests with result_ready held high
      mem_a[70] = 32'd6;
      mem_b[71] = 32'd7;
      mem_a[80] = 32'd2;
      mem_b[81] = 32'd8;
      result_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      len = 11'd1;
      a_base = 10'd70;
      b_base = 10'd71;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = -1;
      for (int c = 1; c <= 20 && cyc < 0; c++) begin
         @(negedge clk);
         if (result_valid) cyc = c;
      end
      chk("b2b_first_valid_cycle", 32'(cyc), 32'd4);
      chk("b2b_first_result", result, 32'd42);
      start = 1'b1;
      a_base = 10'd80;
      b_base = 10'd81;
      @(negedge clk);
      chk("b2b_idle_gap", 32'({busy, result_valid}), 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      cyc = -1;
      for (int c = 1; c <= 20 && cyc < 0; c++) begin
         @(negedge clk);
         if (result_valid) cyc = c;
      end
      chk("b2b_second_valid_cycle", 32'(cyc), 32'd4);
      chk("b2b_second_result", result, 32'd16);
      @(negedge clk);
      result_ready = 1'b0;
      chk("b2b_final_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
